// File: rtl/instruction_decoder_unit_if.sv
// Decode-stage bundle: fetched instruction in, registered control word and register addresses out.
// The IF stage drives the master side; the decoder owns the slave side.
interface instruction_decoder_unit_if;
   logic [15:0] instr;
   logic        rw1;
   logic [2:0]  da1;
   logic [1:0]  md1;
   logic [1:0]  bs1;
   logic        ps1;
   logic        mw1;
   logic [4:0]  fs1;
   logic [2:0]  sh1;
   logic        ma1;
   logic        mb1;
   logic [2:0]  aa1;
   logic [2:0]  ba1;
   logic        cs1;

   modport master (
      output instr,
      input  rw1, da1, md1, bs1, ps1, mw1, fs1, sh1, ma1, mb1, aa1, ba1, cs1
   );

   modport slave (
      input  instr,
      output rw1, da1, md1, bs1, ps1, mw1, fs1, sh1, ma1, mb1, aa1, ba1, cs1
   );
endinterface

// File: rtl/instruction_decoder_unit.sv
// Instruction-decode stage of the 16-bit RISC pipeline: splits the instruction into register
// fields and registers the control word one cycle later; reset yields the all-zero NOP word.
module instruction_decoder_unit (
   input  logic                        clk,
   input  logic                        rst,
   instruction_decoder_unit_if.slave   dec
);

   typedef enum logic [6:0] {
      OP_NOP = 7'b0000000,
      OP_MOV = 7'b1000000,
      OP_ADD = 7'b0000010,
      OP_SUB = 7'b0000101,
      OP_SLT = 7'b1100101,
      OP_AND = 7'b0001000,
      OP_OR  = 7'b0001001,
      OP_XOR = 7'b0001010,
      OP_NOT = 7'b0001011,
      OP_LSL = 7'b0001100,
      OP_LSR = 7'b0001101,
      OP_LD  = 7'b0100001,
      OP_ST  = 7'b0000001,
      OP_ADI = 7'b0100010,
      OP_AIU = 7'b1000010,
      OP_SBI = 7'b0100101,
      OP_ANI = 7'b1001000,
      OP_BZ  = 7'b1100000,
      OP_BNZ = 7'b1100001,
      OP_BRA = 7'b1100010,
      OP_JMR = 7'b1110000,
      OP_JML = 7'b1110001
   } opcode_e;

   typedef enum logic [4:0] {
      FS_A   = 5'b00000,
      FS_ADD = 5'b00010,
      FS_SUB = 5'b00101,
      FS_AND = 5'b01000,
      FS_OR  = 5'b01010,
      FS_XOR = 5'b01100,
      FS_NOT = 5'b01110,
      FS_SHR = 5'b10100,
      FS_SHL = 5'b11000
   } fs_e;

   localparam logic [1:0] MD_FU   = 2'b00;
   localparam logic [1:0] MD_MEM  = 2'b01;
   localparam logic [1:0] MD_SLT  = 2'b10;
   localparam logic [1:0] BS_NONE = 2'b00;
   localparam logic [1:0] BS_Z    = 2'b01;
   localparam logic [1:0] BS_REL  = 2'b10;
   localparam logic [1:0] BS_JMP  = 2'b11;

   typedef struct packed {
      logic       rw;
      logic [1:0] md;
      logic [1:0] bs;
      logic       ps;
      logic       mw;
      fs_e        fs;
      logic       ma;
      logic       mb;
      logic       cs;
   } ctrl_t;

   ctrl_t      ctrl;
   logic [6:0] opcode;

   assign opcode = dec.instr[15:9];

   always_comb begin
      // NOTE: the whole word is cleared first so every opcode, including undefined ones, only
      // sets the bits it needs; this also keeps the case from inferring latches.
      ctrl    = '0;
      ctrl.fs = FS_A;
      ctrl.md = MD_FU;
      ctrl.bs = BS_NONE;
      case (opcode)
         OP_MOV: begin ctrl.rw = 1'b1; ctrl.fs = FS_A;   end
         OP_ADD: begin ctrl.rw = 1'b1; ctrl.fs = FS_ADD; end
         OP_SUB: begin ctrl.rw = 1'b1; ctrl.fs = FS_SUB; end
         OP_SLT: begin ctrl.rw = 1'b1; ctrl.md = MD_SLT; ctrl.fs = FS_SUB; end
         OP_AND: begin ctrl.rw = 1'b1; ctrl.fs = FS_AND; end
         OP_OR:  begin ctrl.rw = 1'b1; ctrl.fs = FS_OR;  end
         OP_XOR: begin ctrl.rw = 1'b1; ctrl.fs = FS_XOR; end
         OP_NOT: begin ctrl.rw = 1'b1; ctrl.fs = FS_NOT; end
         OP_LSL: begin ctrl.rw = 1'b1; ctrl.fs = FS_SHL; end
         OP_LSR: begin ctrl.rw = 1'b1; ctrl.fs = FS_SHR; end
         OP_LD:  begin ctrl.rw = 1'b1; ctrl.md = MD_MEM; end
         OP_ST:  begin ctrl.mw = 1'b1; end
         // Immediate forms take the constant unit on the B bus; ADI/SBI sign-extend, AIU/ANI do not.
         OP_ADI: begin ctrl.rw = 1'b1; ctrl.mb = 1'b1; ctrl.cs = 1'b1; ctrl.fs = FS_ADD; end
         OP_AIU: begin ctrl.rw = 1'b1; ctrl.mb = 1'b1; ctrl.fs = FS_ADD; end
         OP_SBI: begin ctrl.rw = 1'b1; ctrl.mb = 1'b1; ctrl.cs = 1'b1; ctrl.fs = FS_SUB; end
         OP_ANI: begin ctrl.rw = 1'b1; ctrl.mb = 1'b1; ctrl.fs = FS_AND; end
         OP_BZ:  begin ctrl.bs = BS_Z;   ctrl.ps = 1'b0; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
         OP_BNZ: begin ctrl.bs = BS_Z;   ctrl.ps = 1'b1; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
         OP_BRA: begin ctrl.bs = BS_REL; ctrl.mb = 1'b1; ctrl.cs = 1'b1; end
         OP_JMR: begin ctrl.bs = BS_JMP; end
         // Jump-and-link writes PC+1 (A-bus mux) into DR while branching relative.
         OP_JML: begin
            ctrl.rw = 1'b1; ctrl.ma = 1'b1; ctrl.bs = BS_REL; ctrl.mb = 1'b1; ctrl.cs = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every output samples this cycle's decode together.
      if (rst) begin
         dec.rw1 <= 1'b0;
         dec.md1 <= 2'b00;
         dec.bs1 <= 2'b00;
         dec.ps1 <= 1'b0;
         dec.mw1 <= 1'b0;
         dec.fs1 <= 5'b00000;
         dec.ma1 <= 1'b0;
         dec.mb1 <= 1'b0;
         dec.cs1 <= 1'b0;
         dec.da1 <= 3'd0;
         dec.aa1 <= 3'd0;
         dec.ba1 <= 3'd0;
         dec.sh1 <= 3'd0;
      end else begin
         dec.rw1 <= ctrl.rw;
         dec.md1 <= ctrl.md;
         dec.bs1 <= ctrl.bs;
         dec.ps1 <= ctrl.ps;
         dec.mw1 <= ctrl.mw;
         dec.fs1 <= ctrl.fs;
         dec.ma1 <= ctrl.ma;
         dec.mb1 <= ctrl.mb;
         dec.cs1 <= ctrl.cs;
         dec.da1 <= dec.instr[8:6];
         dec.aa1 <= dec.instr[5:3];
         dec.ba1 <= dec.instr[2:0];
         dec.sh1 <= dec.instr[2:0];
      end
   end

endmodule

// File: tb/tb_instruction_decoder_unit.sv
// Self-checking bench for instruction_decoder_unit: directed steps, full opcode sweep and random
// instructions, all compared against a table-driven model of the opcode list.
module tb_instruction_decoder_unit;

   logic clk;
   logic rst;
   instruction_decoder_unit_if dif ();

   instruction_decoder_unit dut (
      .clk (clk),
      .rst (rst),
      .dec (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int fails;

   // Control word {rw, md, bs, ps, mw, fs, ma, mb, cs}, one entry per opcode.
   logic [14:0] ref_tbl [128];
   logic [26:0] prev_exp;
   bit          have_prev;

   task automatic def(input int op, input logic rw, input logic [1:0] md, input logic [1:0] bs,
                      input logic ps, input logic mw, input logic [4:0] fs, input logic ma,
                      input logic mb, input logic cs);
      ref_tbl[op] = {rw, md, bs, ps, mw, fs, ma, mb, cs};
   endtask

   task automatic build_table();
      for (int i = 0; i < 128; i++) ref_tbl[i] = '0;
      //       op          rw    md     bs     ps    mw    fs        ma    mb    cs
      def(7'b1000000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0); // MOV
      def(7'b0000010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b0, 1'b0); // ADD
      def(7'b0000101, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00101, 1'b0, 1'b0, 1'b0); // SUB
      def(7'b1100101, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 5'b00101, 1'b0, 1'b0, 1'b0); // SLT
      def(7'b0001000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b0, 1'b0); // AND
      def(7'b0001001, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b0, 1'b0); // OR
      def(7'b0001010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b01100, 1'b0, 1'b0, 1'b0); // XOR
      def(7'b0001011, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b01110, 1'b0, 1'b0, 1'b0); // NOT
      def(7'b0001100, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b11000, 1'b0, 1'b0, 1'b0); // LSL
      def(7'b0001101, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b10100, 1'b0, 1'b0, 1'b0); // LSR
      def(7'b0100001, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0); // LD
      def(7'b0000001, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0); // ST
      def(7'b0100010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b1, 1'b1); // ADI
      def(7'b1000010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00010, 1'b0, 1'b1, 1'b0); // AIU
      def(7'b0100101, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00101, 1'b0, 1'b1, 1'b1); // SBI
      def(7'b1001000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 5'b01000, 1'b0, 1'b1, 1'b0); // ANI
      def(7'b1100000, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b1); // BZ
      def(7'b1100001, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b1); // BNZ
      def(7'b1100010, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b1); // BRA
      def(7'b1110000, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0); // JMR
      def(7'b1110001, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1); // JML
   endtask

   // Full expected output vector: control word then DA, AA, BA, SH.
   function automatic logic [26:0] model(input logic r, input logic [15:0] i);
      if (r) return '0;
      return {ref_tbl[i[15:9]], i[8:6], i[5:3], i[2:0], i[2:0]};
   endfunction

   function automatic logic [26:0] observed();
      return {dif.rw1, dif.md1, dif.bs1, dif.ps1, dif.mw1, dif.fs1, dif.ma1, dif.mb1, dif.cs1,
              dif.da1, dif.aa1, dif.ba1, dif.sh1};
   endfunction

   task automatic check(input string tag, input logic [26:0] obs, input logic [26:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %07h expected %07h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one cycle: outputs must hold the previous word until the edge, then show the new one.
   task automatic step(input logic r, input logic [15:0] i, input string tag);
      logic [26:0] exp;
      rst       = r;
      dif.instr = i;
      #1;
      if (have_prev) check({tag, "_hold"}, observed(), prev_exp);
      @(posedge clk);
      #1;
      exp = model(r, i);
      check(tag, observed(), exp);
      check_bit({tag, "_rw_mw"}, dif.rw1 & dif.mw1, 1'b0);
      prev_exp  = exp;
      have_prev = 1'b1;
   endtask

   initial begin
      logic [15:0] ri;
      logic        rr;
      tests     = 0;
      fails     = 0;
      have_prev = 1'b0;
      build_table();
      rst       = 1'b1;
      dif.instr = 16'hFFFF;

      // Reset holds every output at zero, then 16'hFFFF decodes as undefined with fields of 7.
      step(1'b1, 16'hFFFF, "rst0");
      check("rst0_zero", observed(), 27'd0);
      step(1'b1, 16'hFFFF, "rst1");
      check("rst1_zero", observed(), 27'd0);
      step(1'b0, 16'hFFFF, "undef_ffff");
      check("undef_ffff_const", observed(), {15'd0, 3'd7, 3'd7, 3'd7, 3'd7});

      // Field pipeline with NOP opcode.
      step(1'b0, 16'h0020, "nop_0020");
      check("fields_0020", {dif.da1, dif.aa1, dif.ba1}, {18'd0, 3'd0, 3'd4, 3'd0});
      step(1'b0, 16'h0060, "nop_0060");
      check("fields_0060", {dif.da1, dif.aa1, dif.ba1}, {18'd0, 3'd1, 3'd4, 3'd0});
      step(1'b0, 16'h0044, "nop_0044");
      check("fields_0044", {dif.da1, dif.aa1, dif.ba1}, {18'd0, 3'd1, 3'd0, 3'd4});
      step(1'b0, 16'h0007, "nop_0007");
      check("fields_0007", {dif.da1, dif.aa1, dif.ba1}, {18'd0, 3'd0, 3'd0, 3'd7});

      // ADD R3,R1,R2.
      step(1'b0, 16'h04CA, "add");
      check("add_fs", {22'd0, dif.fs1}, {22'd0, 5'b00010});
      check_bit("add_rw", dif.rw1, 1'b1);

      // BZ SA=2 SB=5.
      step(1'b0, 16'hC015, "bz");
      check("bz_bs", {25'd0, dif.bs1}, {25'd0, 2'b01});
      check_bit("bz_mb", dif.mb1, 1'b1);
      check_bit("bz_cs", dif.cs1, 1'b1);

      // Every opcode with fixed fields DR=5, SA=2, SB=6.
      for (int op = 0; op < 128; op++) begin
         ri = {op[6:0], 3'd5, 3'd2, 3'd6};
         step(1'b0, ri, $sformatf("sweep_op%02h", op));
      end

      // Mid-stream reset while ADD is presented, then ADD decodes on the next edge.
      step(1'b0, 16'h04CA, "add_pre");
      step(1'b1, 16'h04CA, "add_rst");
      check("add_rst_zero", observed(), 27'd0);
      step(1'b0, 16'h04CA, "add_post");
      check_bit("add_post_rw", dif.rw1, 1'b1);

      // Random instructions with occasional reset.
      for (int n = 0; n < 300; n++) begin
         ri = 16'($urandom);
         if ($urandom_range(0, 1) == 1) ri[15:9] = 7'($urandom_range(0, 127));
         rr = ($urandom_range(0, 15) == 0);
         step(rr, ri, $sformatf("rand%0d", n));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
